// File: rtl/fifo_dc_burst_wr_if.sv
// ----------------------------------------------------------------------------
// fifo_dc_burst_wr_if
// Groups the burst request, source stream and FIFO write-port signals of the
// write-side burst admission controller.
//   slave  : the controller's view (takes requests, beats and FIFO status,
//            drives grant, ready, FIFO write port and error flag)
//   master : the surrounding system's view (opposite directions)
// Signals:
//   burst_req_i/burst_len_i     burst request level and length in beats
//   burst_gnt_o/burst_busy_o    one-cycle grant pulse, not-idle indication
//   in_data_i/in_valid_i/in_last_i/in_ready_o   valid/ready source stream
//   fifo_wr_en_o/fifo_wr_data_o registered FIFO write port
//   fifo_wr_full_i/fifo_wr_free_i FIFO write-domain status
//   err_o                       sticky protocol error
// ----------------------------------------------------------------------------
interface fifo_dc_burst_wr_if #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 64,
    parameter int MAX_LEN = 16
);
    localparam int LENW  = $clog2(MAX_LEN) + 1;
    localparam int FREEW = $clog2(DEPTH) + 1;

    logic             burst_req_i;
    logic [LENW-1:0]  burst_len_i;
    logic             burst_gnt_o;
    logic             burst_busy_o;
    logic [WIDTH-1:0] in_data_i;
    logic             in_valid_i;
    logic             in_last_i;
    logic             in_ready_o;
    logic             fifo_wr_en_o;
    logic [WIDTH-1:0] fifo_wr_data_o;
    logic             fifo_wr_full_i;
    logic [FREEW-1:0] fifo_wr_free_i;
    logic             err_o;

    modport slave (
        input  burst_req_i, burst_len_i, in_data_i, in_valid_i, in_last_i,
               fifo_wr_full_i, fifo_wr_free_i,
        output burst_gnt_o, burst_busy_o, in_ready_o, fifo_wr_en_o,
               fifo_wr_data_o, err_o
    );

    modport master (
        output burst_req_i, burst_len_i, in_data_i, in_valid_i, in_last_i,
               fifo_wr_full_i, fifo_wr_free_i,
        input  burst_gnt_o, burst_busy_o, in_ready_o, fifo_wr_en_o,
               fifo_wr_data_o, err_o
    );
endinterface

// File: rtl/fifo_dc_burst_wr.sv
// ----------------------------------------------------------------------------
// fifo_dc_burst_wr
// Write-side burst admission controller for the dual-clock FIFO. A burst is
// granted only when the FIFO's write-domain free count can hold all of it, so
// a granted burst never stalls on a full FIFO. Beats from a valid/ready source
// are then forwarded to the FIFO write port through a registered stage.
// Ports:
//   wr_clk_i    write-domain clock
//   wr_rst_n_i  asynchronous active-low reset (release expected to be
//               synchronised to wr_clk_i upstream)
//   bus         fifo_dc_burst_wr_if.slave: request, source stream, FIFO port
// ----------------------------------------------------------------------------
module fifo_dc_burst_wr #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 64,
    parameter int MAX_LEN = 16
) (
    input  logic             wr_clk_i,
    input  logic             wr_rst_n_i,
    fifo_dc_burst_wr_if.slave bus
);
    localparam int LENW  = $clog2(MAX_LEN) + 1;
    localparam int FREEW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t           r_state;
    logic [LENW-1:0]  r_count;
    logic             r_gnt;
    logic             r_wrEn;
    logic [WIDTH-1:0] r_wrData;
    logic             r_err;

    logic             w_lenLegal;
    logic [FREEW-1:0] w_lenExt;
    logic             w_fits;
    logic             w_ready;
    logic             w_accept;
    logic             w_lastBeat;

    assign w_lenLegal = (bus.burst_len_i != '0) &&
                        (bus.burst_len_i <= LENW'(MAX_LEN));
    // Both operands are unsigned and FREEW bits wide; LENW never exceeds FREEW.
    assign w_lenExt   = FREEW'(bus.burst_len_i);
    assign w_fits     = (w_lenExt <= bus.fifo_wr_free_i);

    // Ready depends only on state and the full flag, never on in_valid_i.
    assign w_ready    = (r_state == BURST) && !bus.fifo_wr_full_i;
    assign w_accept   = w_ready && bus.in_valid_i;
    assign w_lastBeat = (r_count == LENW'(1));

    // Single FSM: admission in IDLE, beat forwarding in BURST, one settling
    // cycle in WAIT so the final write has reached the FIFO pointer before
    // the free count is evaluated again.
    always_ff @(posedge wr_clk_i or negedge wr_rst_n_i) begin
        if (!wr_rst_n_i) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_gnt    <= 1'b0;
            r_wrEn   <= 1'b0;
            r_wrData <= '0;
            r_err    <= 1'b0;
        end else begin
            r_gnt  <= 1'b0;
            r_wrEn <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.burst_req_i) begin
                        if (!w_lenLegal) begin
                            r_err <= 1'b1;
                        end else if (w_fits) begin
                            r_gnt   <= 1'b1;
                            r_count <= bus.burst_len_i;
                            r_state <= BURST;
                        end
                    end
                end
                BURST: begin
                    // The reservation makes full impossible here; seeing it
                    // means the free count or the FIFO is misbehaving.
                    if (bus.fifo_wr_full_i) begin
                        r_err <= 1'b1;
                    end
                    if (w_accept) begin
                        r_wrEn   <= 1'b1;
                        r_wrData <= bus.in_data_i;
                        r_count  <= r_count - LENW'(1);
                        // in_last_i is only cross-checked; the count ends the burst.
                        if (bus.in_last_i != w_lastBeat) begin
                            r_err <= 1'b1;
                        end
                        if (w_lastBeat) begin
                            r_state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.burst_gnt_o    = r_gnt;
    assign bus.burst_busy_o   = (r_state != IDLE);
    assign bus.in_ready_o     = w_ready;
    assign bus.fifo_wr_en_o   = r_wrEn;
    assign bus.fifo_wr_data_o = r_wrData;
    assign bus.err_o          = r_err;
endmodule

// File: tb/tb_fifo_dc_burst_wr.sv
// ----------------------------------------------------------------------------
// tb_fifo_dc_burst_wr
// Directed self-checking bench for fifo_dc_burst_wr (WIDTH=32, DEPTH=64,
// MAX_LEN=16). Inputs change on the falling edge; outputs are sampled on the
// falling edge, half a period away from the active rising edge.
// ----------------------------------------------------------------------------
module tb_fifo_dc_burst_wr;
    logic wr_clk_i;
    logic wr_rst_n_i;
    int   vectorCount;
    int   missCount;
    int   wrCount;
    int   startCount;

    fifo_dc_burst_wr_if #(.WIDTH(32), .DEPTH(64), .MAX_LEN(16)) busIf ();

    fifo_dc_burst_wr #(.WIDTH(32), .DEPTH(64), .MAX_LEN(16)) dut (
        .wr_clk_i  (wr_clk_i),
        .wr_rst_n_i(wr_rst_n_i),
        .bus       (busIf.slave)
    );

    initial wr_clk_i = 1'b0;
    always #5 wr_clk_i = ~wr_clk_i;

    // Independent tally of FIFO writes, sampled shortly after each edge.
    always @(posedge wr_clk_i) begin
        #2;
        if (busIf.fifo_wr_en_o === 1'b1) wrCount++;
    end

    // Single comparison point: counts every vector and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic req, input logic [4:0] len,
                                 input logic valid, input logic [31:0] data,
                                 input logic last);
        busIf.burst_req_i = req;
        busIf.burst_len_i = len;
        busIf.in_valid_i  = valid;
        busIf.in_data_i   = data;
        busIf.in_last_i   = last;
    endtask

    task automatic nextCycle();
        @(negedge wr_clk_i);
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 5'd0, 1'b0, 32'h0, 1'b0);
        wr_rst_n_i = 1'b0;
        nextCycle();
        wr_rst_n_i = 1'b1;
        nextCycle();
    endtask

    // Raise a request and expect the grant one cycle later, with ready up.
    task automatic requestBurst(input logic [4:0] len, input string tag);
        applyStimulus(1'b1, len, 1'b0, 32'h0, 1'b0);
        nextCycle();
        checkOutput({tag, "_gnt"}, 64'(busIf.burst_gnt_o), 64'd1);
        checkOutput({tag, "_ready"}, 64'(busIf.in_ready_o), 64'd1);
        checkOutput({tag, "_busy"}, 64'(busIf.burst_busy_o), 64'd1);
        busIf.burst_req_i = 1'b0;
    endtask

    // Stream n back-to-back beats starting in the current (grant) cycle and
    // check each registered write, then the WAIT cycle and the return to IDLE.
    task automatic sendBeats(input int n, input int lastAt,
                             input logic [31:0] base, input string tag);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 5'd0, 1'b1, base + 32'(i), i == lastAt);
            nextCycle();
            checkOutput({tag, "_wren"}, 64'(busIf.fifo_wr_en_o), 64'd1);
            checkOutput({tag, "_data"}, 64'(busIf.fifo_wr_data_o), 64'(base + 32'(i)));
            if (i == 0) checkOutput({tag, "_gnt_pulse"}, 64'(busIf.burst_gnt_o), 64'd0);
        end
        applyStimulus(1'b0, 5'd0, 1'b0, 32'h0, 1'b0);
        checkOutput({tag, "_wait_busy"}, 64'(busIf.burst_busy_o), 64'd1);
        checkOutput({tag, "_wait_ready"}, 64'(busIf.in_ready_o), 64'd0);
        nextCycle();
        checkOutput({tag, "_idle_busy"}, 64'(busIf.burst_busy_o), 64'd0);
        checkOutput({tag, "_idle_wren"}, 64'(busIf.fifo_wr_en_o), 64'd0);
    endtask

    initial begin
        logic [6:0]  pat;
        logic [31:0] heldData;
        logic [31:0] drivenData;
        int          beat;

        vectorCount = 0;
        missCount   = 0;
        wrCount     = 0;
        wr_rst_n_i  = 1'b0;
        applyStimulus(1'b0, 5'd0, 1'b0, 32'h0, 1'b0);
        busIf.fifo_wr_full_i = 1'b0;
        busIf.fifo_wr_free_i = 7'd64;
        nextCycle();
        nextCycle();

        // Reset state
        checkOutput("rst_gnt",   64'(busIf.burst_gnt_o),    64'd0);
        checkOutput("rst_busy",  64'(busIf.burst_busy_o),   64'd0);
        checkOutput("rst_ready", 64'(busIf.in_ready_o),     64'd0);
        checkOutput("rst_wren",  64'(busIf.fifo_wr_en_o),   64'd0);
        checkOutput("rst_data",  64'(busIf.fifo_wr_data_o), 64'd0);
        checkOutput("rst_err",   64'(busIf.err_o),          64'd0);
        wr_rst_n_i = 1'b1;
        nextCycle();

        // Basic 16-beat burst into an empty FIFO
        startCount = wrCount;
        requestBurst(5'd16, "basic");
        sendBeats(16, 15, 32'hA000_0000, "basic");
        checkOutput("basic_count", 64'(wrCount - startCount), 64'd16);
        checkOutput("basic_err", 64'(busIf.err_o), 64'd0);

        // Source gaps: valid pattern 1,0,0,1,1,0,1 starting in the grant cycle
        pat      = 7'b1011001;
        heldData = 32'hA000_000F;
        drivenData = 32'h0;
        beat     = 0;
        startCount = wrCount;
        requestBurst(5'd4, "gap");
        for (int i = 0; i <= 7; i++) begin
            if (i > 0) begin
                nextCycle();
                if (pat[i-1]) heldData = drivenData;
                checkOutput($sformatf("gap_wren%0d", i), 64'(busIf.fifo_wr_en_o), 64'(pat[i-1]));
                checkOutput($sformatf("gap_data%0d", i), 64'(busIf.fifo_wr_data_o), 64'(heldData));
            end
            if (i < 7 && pat[i]) begin
                drivenData = 32'hB000_0000 + 32'(beat);
                applyStimulus(1'b0, 5'd0, 1'b1, drivenData, beat == 3);
                beat++;
            end else begin
                applyStimulus(1'b0, 5'd0, 1'b0, 32'hDEAD_BEEF, 1'b0);
            end
        end
        checkOutput("gap_wait_busy", 64'(busIf.burst_busy_o), 64'd1);
        nextCycle();
        checkOutput("gap_idle_busy", 64'(busIf.burst_busy_o), 64'd0);
        checkOutput("gap_count", 64'(wrCount - startCount), 64'd4);
        checkOutput("gap_err", 64'(busIf.err_o), 64'd0);

        // Insufficient space: free=10, len=12; grant once free reaches 12
        busIf.fifo_wr_free_i = 7'd10;
        applyStimulus(1'b1, 5'd12, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            checkOutput($sformatf("space_nognt%0d", i), 64'(busIf.burst_gnt_o), 64'd0);
            checkOutput($sformatf("space_idle%0d", i), 64'(busIf.burst_busy_o), 64'd0);
        end
        busIf.fifo_wr_free_i = 7'd11;
        nextCycle();
        checkOutput("space_free11", 64'(busIf.burst_gnt_o), 64'd0);
        busIf.fifo_wr_free_i = 7'd12;
        nextCycle();
        checkOutput("space_free12_gnt", 64'(busIf.burst_gnt_o), 64'd1);
        busIf.burst_req_i = 1'b0;
        sendBeats(12, 11, 32'hC000_0000, "space");
        checkOutput("space_err", 64'(busIf.err_o), 64'd0);
        busIf.fifo_wr_free_i = 7'd64;

        // Back-to-back len=1 requests with the request held throughout
        applyStimulus(1'b1, 5'd1, 1'b0, 32'h0, 1'b0);
        nextCycle();
        checkOutput("b2b_gnt1", 64'(busIf.burst_gnt_o), 64'd1);
        applyStimulus(1'b1, 5'd1, 1'b1, 32'hD000_0001, 1'b1);
        nextCycle();
        checkOutput("b2b_edge1", 64'(busIf.burst_gnt_o), 64'd0);
        checkOutput("b2b_wren", 64'(busIf.fifo_wr_en_o), 64'd1);
        applyStimulus(1'b1, 5'd1, 1'b0, 32'h0, 1'b0);
        nextCycle();
        checkOutput("b2b_edge2", 64'(busIf.burst_gnt_o), 64'd0);
        nextCycle();
        checkOutput("b2b_gnt2", 64'(busIf.burst_gnt_o), 64'd1);
        busIf.burst_req_i = 1'b0;
        sendBeats(1, 0, 32'hD000_0002, "b2b");
        checkOutput("b2b_err", 64'(busIf.err_o), 64'd0);

        // Full flag while in BURST holds the beat off and flags an error
        requestBurst(5'd2, "full");
        busIf.fifo_wr_full_i = 1'b1;
        applyStimulus(1'b0, 5'd0, 1'b1, 32'hE000_0000, 1'b0);
        #1;
        checkOutput("full_ready", 64'(busIf.in_ready_o), 64'd0);
        nextCycle();
        checkOutput("full_wren", 64'(busIf.fifo_wr_en_o), 64'd0);
        checkOutput("full_err", 64'(busIf.err_o), 64'd1);
        busIf.fifo_wr_full_i = 1'b0;
        sendBeats(2, 1, 32'hE000_0000, "full");
        doReset();

        // Illegal length 0
        applyStimulus(1'b1, 5'd0, 1'b0, 32'h0, 1'b0);
        nextCycle();
        busIf.burst_req_i = 1'b0;
        checkOutput("len0_gnt", 64'(busIf.burst_gnt_o), 64'd0);
        checkOutput("len0_err", 64'(busIf.err_o), 64'd1);
        checkOutput("len0_busy", 64'(busIf.burst_busy_o), 64'd0);
        doReset();
        checkOutput("err_cleared", 64'(busIf.err_o), 64'd0);

        // Illegal length 17
        applyStimulus(1'b1, 5'd17, 1'b0, 32'h0, 1'b0);
        nextCycle();
        busIf.burst_req_i = 1'b0;
        checkOutput("len17_gnt", 64'(busIf.burst_gnt_o), 64'd0);
        checkOutput("len17_err", 64'(busIf.err_o), 64'd1);
        checkOutput("len17_busy", 64'(busIf.burst_busy_o), 64'd0);
        doReset();

        // Misplaced in_last_i: len=3 with last on beat 2
        startCount = wrCount;
        requestBurst(5'd3, "last");
        sendBeats(3, 1, 32'hF000_0000, "last");
        checkOutput("last_count", 64'(wrCount - startCount), 64'd3);
        checkOutput("last_err", 64'(busIf.err_o), 64'd1);
        doReset();

        // Reset in the middle of an 8-beat burst
        startCount = wrCount;
        requestBurst(5'd8, "mid");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 5'd0, 1'b1, 32'h1000_0000 + 32'(i), 1'b0);
            nextCycle();
            checkOutput($sformatf("mid_data%0d", i), 64'(busIf.fifo_wr_data_o), 64'(32'h1000_0000 + 32'(i)));
        end
        applyStimulus(1'b0, 5'd0, 1'b1, 32'h1000_0003, 1'b0);
        checkOutput("mid_count3", 64'(wrCount - startCount), 64'd3);
        #1;
        wr_rst_n_i = 1'b0;
        #1;
        checkOutput("mid_rst_gnt",   64'(busIf.burst_gnt_o),    64'd0);
        checkOutput("mid_rst_busy",  64'(busIf.burst_busy_o),   64'd0);
        checkOutput("mid_rst_ready", 64'(busIf.in_ready_o),     64'd0);
        checkOutput("mid_rst_wren",  64'(busIf.fifo_wr_en_o),   64'd0);
        checkOutput("mid_rst_data",  64'(busIf.fifo_wr_data_o), 64'd0);
        checkOutput("mid_rst_err",   64'(busIf.err_o),          64'd0);
        nextCycle();
        nextCycle();
        applyStimulus(1'b0, 5'd0, 1'b0, 32'h0, 1'b0);
        wr_rst_n_i = 1'b1;
        nextCycle();
        nextCycle();
        checkOutput("mid_post_wren", 64'(busIf.fifo_wr_en_o), 64'd0);
        checkOutput("mid_post_busy", 64'(busIf.burst_busy_o), 64'd0);
        checkOutput("mid_total", 64'(wrCount - startCount), 64'd3);
        requestBurst(5'd2, "fresh");
        sendBeats(2, 1, 32'h2000_0000, "fresh");
        checkOutput("fresh_err", 64'(busIf.err_o), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end
endmodule

// File: doc/fifo_dc_burst_wr.md
# fifo_dc_burst_wr

Write-side burst admission controller for the dual-clock FIFO. It accepts a burst request of known length and grants it only when the FIFO's write-domain free count can hold the whole burst. It then streams exactly that many beats from a valid/ready source into the FIFO write port through a registered output stage. Bursts therefore never stall mid-transfer on a full FIFO, and the reader sees each burst complete once its first word arrives.

## Interface
- WIDTH, 32, data width; equals the FIFO write width
- DEPTH, 64, FIFO write-side depth in words; power of two
- MAX_LEN, 16, maximum burst length in beats; MAX_LEN ≤ DEPTH
- wr_clk_i  in  1  write-domain clock
- wr_rst_n_i  in  1  asynchronous, active-low reset
- burst_req_i  in  1  burst request; level, held until granted
- burst_len_i  in  $clog2(MAX_LEN)+1  requested beats; sampled while burst_req_i=1 in IDLE
- burst_gnt_o  out  1  one-cycle grant pulse
- burst_busy_o  out  1  high in any state other than IDLE
- in_data_i  in  WIDTH  source data
- in_valid_i  in  1  source valid
- in_last_i  in  1  source marks final beat; checked only
- in_ready_o  out  1  block accepts a beat
- fifo_wr_en_o  out  1  FIFO write enable (registered)
- fifo_wr_data_o  out  WIDTH  FIFO write data (registered)
- fifo_wr_full_i  in  1  FIFO full flag
- fifo_wr_free_i  in  $clog2(DEPTH)+1  FIFO free words, write domain
- err_o  out  1  sticky protocol error; cleared only by reset

## Operation
- States: IDLE, BURST, WAIT.
- **IDLE**
  - A request is legal when 1 ≤ burst_len_i ≤ MAX_LEN.
  - Legal request with fifo_wr_free_i ≥ burst_len_i: at the next edge, burst_gnt_o=1 for one cycle, beat counter loads burst_len_i, state goes to BURST.
  - Legal request with insufficient free space: stay in IDLE, no grant, re-evaluate every cycle.
  - Illegal length with burst_req_i=1: set err_o, no grant, stay in IDLE.
- **BURST**
  - in_ready_o = ~fifo_wr_full_i.
  - A beat is accepted when in_valid_i & in_ready_o.
  - Each accepted beat: at the next edge, fifo_wr_en_o=1 and fifo_wr_data_o=in_data_i; counter decrements.
  - Cycles with no accepted beat: fifo_wr_en_o=0 next cycle; fifo_wr_data_o holds its value.
  - Accepting the beat with counter=1: go to WAIT.
- **WAIT**: exactly one cycle, in_ready_o=0, then IDLE. This lets the final registered write reach the FIFO pointer, so fifo_wr_free_i is current when IDLE evaluates it.
- **in_last_i check**: err_o is set when in_last_i=1 on an accepted beat with counter≠1, or in_last_i=0 on the beat with counter=1. The counter alone terminates the burst.
- **Full flag**: fifo_wr_full_i=1 while in BURST sets err_o, since the reservation guarantees it cannot happen. The beat is held off through in_ready_o.
- **Width rules**: the free comparison is unsigned, zero-extending both operands to $clog2(DEPTH)+1 bits. The counter is $clog2(MAX_LEN)+1 bits and never wraps.
- **Request during BURST/WAIT**: burst_req_i is ignored; it is evaluated again on return to IDLE.

## Timing
- **Reset (asynchronous assert, synchronous release)**
  - State returns to IDLE and the counter clears.
  - burst_gnt_o=0, burst_busy_o=0, in_ready_o=0, fifo_wr_en_o=0, fifo_wr_data_o=0, err_o=0.
- **Reset mid-burst**: the burst is aborted and words already written stay in the FIFO. No pending write is issued after release.
- **Request to grant**: 1 cycle. in_ready_o rises in the same cycle as burst_gnt_o.
- **Accepted beat to FIFO write**: 1 cycle.
- **Back-to-back bursts**: minimum gap from the last accepted beat to the next burst_gnt_o is 3 edges (WAIT edge, IDLE evaluation edge, grant edge).
- **Throughput in BURST**: 1 beat per cycle, with in_valid_i held high and FIFO not full.
- **Combinational paths**: in_ready_o depends only on state and fifo_wr_full_i, never on in_valid_i.

## Test plan
- **Basic burst**: DEPTH=64, empty FIFO (free=64), req with len=16, 16 continuous beats with in_last_i on beat 16.
  - burst_gnt_o pulses 1 cycle after req.
  - fifo_wr_en_o high for 16 consecutive cycles, starting 1 cycle after the first accepted beat, data in order.
  - busy falls 2 cycles after the last beat; err_o=0.
- **Insufficient space**: free=10, len=12; no grant. The reader drains 2 words, so free becomes 12; grant follows 1 cycle after free reaches 12.
- **Source gaps**: len=4, in_valid_i pattern 1,0,0,1,1,0,1. Exactly 4 writes, one cycle after each accepted beat; fifo_wr_en_o stays low in gap cycles.
- **Protocol errors**:
  - len=0 sets err_o with no grant.
  - A separate run with len=17 also sets err_o with no grant.
  - A separate run with len=3 and in_last_i on beat 2 completes 3 writes and sets err_o.
- **Reset mid-burst**: len=8, wr_rst_n_i asserted after beat 3.
  - All outputs 0 immediately.
  - Exactly 3 writes total (the third registered write lands only if the edge precedes reset).
  - After release, a fresh len=2 burst is granted normally.
- **Back-to-back**: two queued len=1 requests. The second grant occurs 3 edges after the first burst's beat is accepted.
